dist_huff_ctrl: RTL and testbench
=================================

Name: dist_huff_ctrl

Overview:
- Sequencer wrapped around the DEFLATE distance-code canonical table builder.
- Accepts a packed 16-symbol code-length tree and resets the builder.
- Starts the builder and waits for it to finish.
- Then decodes a serial bitstream, MSB-first per code, into 4-bit distance symbols.
- Sits between the bit-unpacker and the LZ77 copy stage, and owns every builder control pin.

Parameters:
- MAXLEN, 8, longest legal code length; bits beyond this without a match raise an error.
- NSYM, 16, number of distance symbols in the tree (4-bit length each).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  new tree offered
- cfg_ready  out  1  tree accepted when cfg_valid&cfg_ready
- cfg_tree  in  64  nibble i = code length of symbol i (0 = unused)
- cfg_err  out  1  one-cycle pulse: tree rejected
- bit_valid  in  1  serial bit offered
- bit_ready  out  1  bit accepted when bit_valid&bit_ready
- bit_in  in  1  code bit, first bit = MSB of code
- sym_valid  out  1  decoded symbol available
- sym_ready  in  1  consumer takes symbol
- sym_out  out  4  decoded symbol
- sym_len  out  4  code length consumed (1..8)
- dec_err  out  1  one-cycle pulse: no match within MAXLEN bits
- tbl_ok  out  1  table built and decoder usable
- bld_rst_n  out  1  builder reset, active-low
- bld_enb  out  1  builder start
- bld_tree  out  64  registered copy of accepted cfg_tree
- bld_code  out  8  code-value lookup address
- bld_len  out  4  length select for count readback
- bld_fin  in  1  builder done
- bld_symb  in  4  symbol at bld_code
- bld_count  in  4  number of codes of length bld_len

Behaviour:
- Reset (rst=1): state IDLE, all outputs 0 except cfg_ready=1; bld_rst_n=0 whenever rst=1; code/first/len regs cleared; tree reg cleared.
- States: IDLE, BRST, BRUN, DEC, CHK, OUT, ERR.
- IDLE -> cfg handshake:
  - Tree rejected if all 16 nibbles are equal and nonzero (4-bit count would wrap to 0): pulse cfg_err, stay IDLE.
  - Otherwise latch bld_tree and go to BRST.
- BRST: one cycle, bld_rst_n=0, tbl_ok=0 -> BRUN.
- BRUN: bld_enb=1 held until bld_fin=1, then -> DEC with tbl_ok=1.
  - No timeout; builder needs about 130 cycles.
- DEC: bit_ready=1; on bit handshake:
  - len<=len+1, code<={code[6:0],bit_in} -> CHK.
  - cfg_ready=1 only in DEC with len==0 (symbol boundary); a cfg handshake there goes to BRST, tbl_ok drops.
  - If cfg and bit are both valid at a boundary, cfg wins and the bit is not accepted.
- CHK: bld_len=len, bld_code=code.
  - first is the first canonical code at this length: first_0=0, first_L=(first_{L-1}+count_{L-1})<<1.
  - Sum computed in 9 bits, truncated to 8.
  - Match iff code>=first and (code-first)<bld_count.
  - Match: latch sym_out=bld_symb, sym_len=len -> OUT.
  - No match and len==MAXLEN -> ERR.
  - Otherwise first<=(first+bld_count)<<1, prevcount saved -> DEC.
- OUT: sym_valid=1, outputs stable until sym_ready.
  - On handshake: code, first, len cleared -> DEC.
  - bit_ready=0 throughout OUT.
- ERR: dec_err pulses one cycle; code/first/len cleared; tbl_ok=0 -> IDLE; a new tree is required.
- Latency: final bit accepted in cycle t -> sym_valid high in cycle t+2. Minimum throughput is one bit per 2 cycles.
- Reset mid-operation: immediate return to IDLE; an in-flight symbol is discarded; builder held in reset.

Decomposition:
- Shared package dcu_pkg holds:
  - state encoding constants
  - MAXLEN, NSYM
  - tree-nibble width
  - canonical-first update function: (first+count)<<1, 8-bit.
- Natural sub-module: dist_canon_step, the combinational match/next-first evaluator. The FSM stays in the top.
- The builder is instantiated beside this block, not inside it.

Test Plan:
- Tree 64'h0000_0000_0000_3321:
  - cfg handshake -> bld_rst_n low exactly 1 cycle, bld_enb high until bld_fin, then tbl_ok=1.
  - Bits 1,1,0 -> sym_out=2, sym_len=3, sym_valid 2 cycles after third bit.
- Same tree, bits 0 / 1,0 / 1,1,1 back-to-back with sym_ready=1 -> symbols 0 (len 1), 1 (len 2), 3 (len 3) in order.
- Tree 64'h0000_0000_0000_0022, bits 1 x8 -> no sym_valid, dec_err pulse after 8th CHK, tbl_ok=0, state IDLE.
- Tree 64'h4444_4444_4444_4444 -> cfg_err pulse, bld_rst_n/bld_enb untouched, tbl_ok stays 0.
- Backpressure: sym_ready low 5 cycles on a decoded symbol -> sym_out/sym_len stable, bit_ready=0.
  - Then a new tree at the boundary -> rebuild, and the next decode uses the new table.
- Reset mid-decode: rst after 2 of 3 bits -> next cycle all outputs at reset values, bld_rst_n=0, no sym_valid.

Source files
------------

// File: rtl/dcu_pkg.sv
// Shared definitions for the DEFLATE distance-code decode controller:
// sizes, FSM state encoding and the canonical-code helper functions.
package dcu_pkg;

  localparam int MAXLEN = 8;
  localparam int NSYM   = 16;
  localparam int LEN_W  = 4;
  localparam int TREE_W = NSYM * LEN_W;
  localparam int CODE_W = MAXLEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BRST,
    S_BRUN,
    S_DEC,
    S_CHK,
    S_OUT,
    S_ERR
  } state_e;

  // First canonical code of the next length: (first + count) << 1, kept to 8 bits.
  function automatic logic [CODE_W-1:0] next_first(input logic [CODE_W-1:0] first,
                                                   input logic [LEN_W-1:0]  count);
    logic [CODE_W:0] sum;
    sum = {1'b0, first} + (CODE_W+1)'(count);
    return CODE_W'({sum, 1'b0});
  endfunction

  // A tree whose 16 lengths are all equal and nonzero overflows the 4-bit count.
  function automatic logic tree_degenerate(input logic [TREE_W-1:0] tree);
    logic same;
    same = 1'b1;
    for (int i = 1; i < NSYM; i++) begin
      if (tree[i*LEN_W +: LEN_W] != tree[LEN_W-1:0]) same = 1'b0;
    end
    return same && (tree[LEN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/dist_canon_step.sv
// Combinational canonical-Huffman step: does the current code match at this
// length, is this the last legal length, and what is the next first code.
module dist_canon_step
  import dcu_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  input  logic [CODE_W-1:0] first_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [LEN_W-1:0]  count_i,
  output logic              match_o,
  output logic              last_o,
  output logic [CODE_W-1:0] first_nxt_o
);

  logic [CODE_W-1:0] offset;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    offset      = code_i - first_i;
    match_o     = (code_i >= first_i) && (offset < CODE_W'(count_i));
    last_o      = (len_i == LEN_W'(MAXLEN));
    first_nxt_o = next_first(first_i, count_i);
  end

endmodule

// File: rtl/dist_huff_ctrl.sv
// Sequencer around the distance-code table builder: accepts a code-length tree,
// runs the builder, then decodes a serial MSB-first bitstream into symbols.
module dist_huff_ctrl
  import dcu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [TREE_W-1:0] cfg_tree,
  output logic              cfg_err,
  input  logic              bit_valid,
  output logic              bit_ready,
  input  logic              bit_in,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic [LEN_W-1:0]  sym_out,
  output logic [LEN_W-1:0]  sym_len,
  output logic              dec_err,
  output logic              tbl_ok,
  output logic              bld_rst_n,
  output logic              bld_enb,
  output logic [TREE_W-1:0] bld_tree,
  output logic [CODE_W-1:0] bld_code,
  output logic [LEN_W-1:0]  bld_len,
  input  logic              bld_fin,
  input  logic [LEN_W-1:0]  bld_symb,
  input  logic [LEN_W-1:0]  bld_count
);

  state_e            state_q;
  logic              cfg_ready_q, cfg_err_q, bit_ready_q, sym_valid_q, dec_err_q;
  logic              tbl_ok_q, bld_rst_n_q, bld_enb_q;
  logic [LEN_W-1:0]  sym_out_q, sym_len_q, len_q;
  logic [TREE_W-1:0] tree_q;
  logic [CODE_W-1:0] code_q, first_q, first_d;
  logic              match, last_len, cfg_take;

  dist_canon_step u_step (
    .code_i      (code_q),
    .first_i     (first_q),
    .len_i       (len_q),
    .count_i     (bld_count),
    .match_o     (match),
    .last_o      (last_len),
    .first_nxt_o (first_d)
  );

  assign cfg_take = cfg_valid && cfg_ready_q;

  // NOTE: all state is updated with non-blocking assignments in one clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= 1'b0;
      bit_ready_q <= 1'b0;
      sym_valid_q <= 1'b0;
      dec_err_q   <= 1'b0;
      tbl_ok_q    <= 1'b0;
      bld_rst_n_q <= 1'b0;
      bld_enb_q   <= 1'b0;
      sym_out_q   <= '0;
      sym_len_q   <= '0;
      tree_q      <= '0;
      code_q      <= '0;
      first_q     <= '0;
      len_q       <= '0;
    end else begin
      cfg_err_q <= 1'b0;
      dec_err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DEC: begin
          if (cfg_take) begin
            if (tree_degenerate(cfg_tree)) begin
              cfg_err_q <= 1'b1;
            end else begin
              tree_q      <= cfg_tree;
              cfg_ready_q <= 1'b0;
              bit_ready_q <= 1'b0;
              tbl_ok_q    <= 1'b0;
              bld_rst_n_q <= 1'b0;
              state_q     <= S_BRST;
            end
          end else if (state_q == S_DEC && bit_valid) begin
            code_q      <= {code_q[CODE_W-2:0], bit_in};
            len_q       <= len_q + LEN_W'(1);
            bit_ready_q <= 1'b0;
            cfg_ready_q <= 1'b0;
            state_q     <= S_CHK;
          end
        end
        S_BRST: begin
          bld_rst_n_q <= 1'b1;
          bld_enb_q   <= 1'b1;
          state_q     <= S_BRUN;
        end
        S_BRUN: begin
          if (bld_fin) begin
            bld_enb_q   <= 1'b0;
            tbl_ok_q    <= 1'b1;
            bit_ready_q <= 1'b1;
            cfg_ready_q <= 1'b1;
            code_q      <= '0;
            first_q     <= '0;
            len_q       <= '0;
            state_q     <= S_DEC;
          end
        end
        S_CHK: begin
          if (match) begin
            sym_out_q   <= bld_symb;
            sym_len_q   <= len_q;
            sym_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (last_len) begin
            dec_err_q <= 1'b1;
            tbl_ok_q  <= 1'b0;
            code_q    <= '0;
            first_q   <= '0;
            len_q     <= '0;
            state_q   <= S_ERR;
          end else begin
            first_q     <= first_d;
            bit_ready_q <= 1'b1;
            state_q     <= S_DEC;
          end
        end
        S_OUT: begin
          if (sym_ready) begin
            sym_valid_q <= 1'b0;
            code_q      <= '0;
            first_q     <= '0;
            len_q       <= '0;
            bit_ready_q <= 1'b1;
            cfg_ready_q <= 1'b1;
            state_q     <= S_DEC;
          end
        end
        S_ERR: begin
          cfg_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A tree offered at a symbol boundary takes priority over a bit.
  assign bit_ready = bit_ready_q && !cfg_take;
  assign bld_rst_n = bld_rst_n_q && !rst;
  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign sym_valid = sym_valid_q;
  assign sym_out   = sym_out_q;
  assign sym_len   = sym_len_q;
  assign dec_err   = dec_err_q;
  assign tbl_ok    = tbl_ok_q;
  assign bld_enb   = bld_enb_q;
  assign bld_tree  = tree_q;
  assign bld_code  = code_q;
  assign bld_len   = len_q;

endmodule

// File: tb/tb_dist_huff_ctrl.sv
// Directed bench for dist_huff_ctrl, with a behavioural canonical table builder
// attached to the builder pins.
module tb_dist_huff_ctrl;

  localparam int BLD_LAT = 130;

  logic        clk = 1'b0;
  logic        rst, cfg_valid, bit_valid, bit_in, sym_ready;
  logic [63:0] cfg_tree;
  logic        cfg_ready, cfg_err, bit_ready, sym_valid, dec_err, tbl_ok;
  logic [3:0]  sym_out, sym_len, bld_len, bld_symb, bld_count;
  logic        bld_rst_n, bld_enb, bld_fin;
  logic [63:0] bld_tree;
  logic [7:0]  bld_code;
  int          bm_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  dist_huff_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_tree(cfg_tree), .cfg_err(cfg_err),
    .bit_valid(bit_valid), .bit_ready(bit_ready), .bit_in(bit_in),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_out(sym_out), .sym_len(sym_len),
    .dec_err(dec_err), .tbl_ok(tbl_ok),
    .bld_rst_n(bld_rst_n), .bld_enb(bld_enb), .bld_tree(bld_tree),
    .bld_code(bld_code), .bld_len(bld_len),
    .bld_fin(bld_fin), .bld_symb(bld_symb), .bld_count(bld_count)
  );

  // Builder model: number of codes of a given length.
  function automatic logic [3:0] model_count(input logic [63:0] t, input logic [3:0] l);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) if (l != 0 && t[i*4 +: 4] == l) c++;
    return 4'(c);
  endfunction

  // Builder model: symbol owning canonical code value c.
  function automatic logic [3:0] model_symb(input logic [63:0] t, input logic [7:0] c);
    int cnt[16];
    int nc[16];
    int f;
    for (int l = 0; l < 16; l++) cnt[l] = 0;
    for (int i = 0; i < 16; i++) cnt[t[i*4 +: 4]]++;
    cnt[0] = 0;
    f = 0;
    nc[0] = 0;
    for (int l = 1; l < 16; l++) begin
      f = (f + cnt[l-1]) << 1;
      nc[l] = f;
    end
    for (int i = 0; i < 16; i++) begin
      if (t[i*4 +: 4] != 0) begin
        if (nc[t[i*4 +: 4]] == int'(c)) return 4'(i);
        nc[t[i*4 +: 4]]++;
      end
    end
    return 4'd0;
  endfunction

  assign bld_count = model_count(bld_tree, bld_len);
  assign bld_symb  = model_symb(bld_tree, bld_code);

  always @(posedge clk) begin
    if (!bld_rst_n) begin
      bm_cnt  <= 0;
      bld_fin <= 1'b0;
    end else if (bld_enb && !bld_fin) begin
      bm_cnt <= bm_cnt + 1;
      if (bm_cnt == BLD_LAT - 1) bld_fin <= 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_tree(input logic [63:0] t, input logic with_bit);
    int  k;
    logic enb_ok;
    n_checks++;
    if (cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL build_cfg_ready: got %b want 1", cfg_ready);
    end
    cfg_tree  = t;
    cfg_valid = 1'b1;
    bit_valid = with_bit;
    bit_in    = 1'b1;
    #1;
    if (with_bit) begin
      n_checks++;
      if (bit_ready !== 1'b0) begin
        n_fail++; $display("FAIL cfg_wins_bit_ready: got %b want 0", bit_ready);
      end
    end
    step();
    cfg_valid = 1'b0;
    bit_valid = 1'b0;
    n_checks++;
    if (bld_rst_n !== 1'b0 || tbl_ok !== 1'b0 || bld_enb !== 1'b0 || bld_tree !== t) begin
      n_fail++;
      $display("FAIL brst_state: rst_n=%b tbl_ok=%b enb=%b tree=%h want 0 0 0 %h",
               bld_rst_n, tbl_ok, bld_enb, bld_tree, t);
    end
    step();
    n_checks++;
    if (bld_rst_n !== 1'b1 || bld_enb !== 1'b1) begin
      n_fail++; $display("FAIL brun_state: rst_n=%b enb=%b want 1 1", bld_rst_n, bld_enb);
    end
    k = 0;
    enb_ok = 1'b1;
    while (tbl_ok !== 1'b1 && k < 400) begin
      if (bld_enb !== 1'b1 || bld_rst_n !== 1'b1) enb_ok = 1'b0;
      step();
      k++;
    end
    n_checks++;
    if (!enb_ok) begin
      n_fail++; $display("FAIL enb_held: bld_enb/bld_rst_n dropped before bld_fin, want held 1");
    end
    n_checks++;
    if (tbl_ok !== 1'b1 || bld_enb !== 1'b0 || bit_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL build_done: tbl_ok=%b enb=%b bit_ready=%b cfg_ready=%b want 1 0 1 1",
               tbl_ok, bld_enb, bit_ready, cfg_ready);
    end
  endtask

  task automatic send_bit(input logic b);
    int k;
    k = 0;
    while (bit_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (bit_ready !== 1'b1) begin
      n_fail++; $display("FAIL bit_ready_wait: got %b want 1 within 20 cycles", bit_ready);
    end
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
  endtask

  task automatic get_sym(input logic [3:0] es, input logic [3:0] el);
    int k;
    k = 0;
    while (sym_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_checks++;
    if (sym_valid !== 1'b1 || sym_out !== es || sym_len !== el) begin
      n_fail++;
      $display("FAIL get_sym: valid=%b sym=%0d len=%0d want 1 %0d %0d", sym_valid, sym_out, sym_len, es, el);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    cfg_tree = '0;
    step();
    step();
    n_checks++;
    if (cfg_ready !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0 || tbl_ok !== 1'b0 ||
        bld_rst_n !== 1'b0 || bld_enb !== 1'b0 || cfg_err !== 1'b0 || dec_err !== 1'b0 ||
        bld_tree !== 64'h0 || bld_code !== 8'h0 || bld_len !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_state: cfg_ready=%b bit_ready=%b sym_valid=%b tbl_ok=%b rst_n=%b enb=%b want 1 0 0 0 0 0",
               cfg_ready, bit_ready, sym_valid, tbl_ok, bld_rst_n, bld_enb);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_decode();
    build_tree(64'h0000_0000_0000_3321, 1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    n_checks++;
    if (sym_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_t1: sym_valid=%b want 0", sym_valid);
    end
    step();
    n_checks++;
    if (sym_valid !== 1'b1 || sym_out !== 4'd2 || sym_len !== 4'd3 || bit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t2: valid=%b sym=%0d len=%0d bit_ready=%b want 1 2 3 0",
               sym_valid, sym_out, sym_len, bit_ready);
    end
    sym_ready = 1'b1;
    step();
    sym_ready = 1'b0;
    n_checks++;
    if (sym_valid !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("FAIL sym_consume: valid=%b cfg_ready=%b want 0 1", sym_valid, cfg_ready);
    end
  endtask

  task automatic test_back_to_back();
    sym_ready = 1'b1;
    send_bit(1'b0);
    get_sym(4'd0, 4'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    get_sym(4'd1, 4'd2);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    get_sym(4'd3, 4'd3);
    step();
    sym_ready = 1'b0;
  endtask

  task automatic test_decode_error();
    logic seen_sym;
    build_tree(64'h0000_0000_0000_0022, 1'b0);
    seen_sym = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      if (sym_valid === 1'b1 || dec_err === 1'b1) seen_sym = 1'b1;
    end
    n_checks++;
    if (seen_sym) begin
      n_fail++; $display("FAIL err_early: sym_valid or dec_err seen before 8th check, want none");
    end
    step();
    n_checks++;
    if (dec_err !== 1'b1 || tbl_ok !== 1'b0 || sym_valid !== 1'b0) begin
      n_fail++; $display("FAIL dec_err_pulse: dec_err=%b tbl_ok=%b valid=%b want 1 0 0", dec_err, tbl_ok, sym_valid);
    end
    step();
    n_checks++;
    if (dec_err !== 1'b0 || cfg_ready !== 1'b1 || bit_ready !== 1'b0 || tbl_ok !== 1'b0) begin
      n_fail++;
      $display("FAIL err_to_idle: dec_err=%b cfg_ready=%b bit_ready=%b tbl_ok=%b want 0 1 0 0",
               dec_err, cfg_ready, bit_ready, tbl_ok);
    end
  endtask

  task automatic test_degenerate_tree();
    cfg_tree  = 64'h4444_4444_4444_4444;
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_err !== 1'b1 || bld_rst_n !== 1'b1 || bld_enb !== 1'b0 || tbl_ok !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_err_pulse: err=%b rst_n=%b enb=%b tbl_ok=%b cfg_ready=%b want 1 1 0 0 1",
               cfg_err, bld_rst_n, bld_enb, tbl_ok, cfg_ready);
    end
    step();
    n_checks++;
    if (cfg_err !== 1'b0 || bld_rst_n !== 1'b1 || tbl_ok !== 1'b0) begin
      n_fail++; $display("FAIL cfg_err_after: err=%b rst_n=%b tbl_ok=%b want 0 1 0", cfg_err, bld_rst_n, tbl_ok);
    end
  endtask

  task automatic test_backpressure_rebuild();
    logic stable;
    build_tree(64'h0000_0000_0000_3321, 1'b0);
    send_bit(1'b0);
    get_sym(4'd0, 4'd1);
    stable = 1'b1;
    bit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sym_valid !== 1'b1 || sym_out !== 4'd0 || sym_len !== 4'd1 || bit_ready !== 1'b0) stable = 1'b0;
    end
    bit_valid = 1'b0;
    n_checks++;
    if (!stable) begin
      n_fail++; $display("FAIL backpressure: valid=%b sym=%0d len=%0d bit_ready=%b want 1 0 1 0 held",
                         sym_valid, sym_out, sym_len, bit_ready);
    end
    sym_ready = 1'b1;
    step();
    sym_ready = 1'b0;
    n_checks++;
    if (bld_rst_n !== 1'b1 || tbl_ok !== 1'b1) begin
      n_fail++; $display("FAIL pre_rebuild: rst_n=%b tbl_ok=%b want 1 1", bld_rst_n, tbl_ok);
    end
    build_tree(64'h0000_0000_0000_1233, 1'b1);
    sym_ready = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    get_sym(4'd0, 4'd3);
    send_bit(1'b0);
    get_sym(4'd3, 4'd1);
    step();
    sym_ready = 1'b0;
  endtask

  task automatic test_reset_mid_decode();
    logic quiet;
    send_bit(1'b1);
    send_bit(1'b1);
    rst = 1'b1;
    step();
    n_checks++;
    if (cfg_ready !== 1'b1 || bit_ready !== 1'b0 || sym_valid !== 1'b0 || tbl_ok !== 1'b0 ||
        bld_rst_n !== 1'b0 || bld_enb !== 1'b0 || sym_out !== 4'd0 || sym_len !== 4'd0 ||
        bld_code !== 8'h0 || bld_len !== 4'h0 || bld_tree !== 64'h0) begin
      n_fail++;
      $display("FAIL mid_reset: cfg_ready=%b bit_ready=%b valid=%b tbl_ok=%b rst_n=%b code=%h len=%0d want 1 0 0 0 0 00 0",
               cfg_ready, bit_ready, sym_valid, tbl_ok, bld_rst_n, bld_code, bld_len);
    end
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (sym_valid !== 1'b0 || bit_ready !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++; $display("FAIL post_reset_quiet: valid=%b bit_ready=%b want 0 0", sym_valid, bit_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_decode();
    test_back_to_back();
    test_decode_error();
    test_degenerate_tree();
    test_backpressure_rebuild();
    test_reset_mid_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
